// File: rtl/vm_pkg.sv
// Shared definitions for the vending machine datapath and its change dispenser.
package vm_pkg;

  // Width of the change value handed over by vending_machine.
  localparam int unsigned CHANGE_W = 4;

  localparam logic [CHANGE_W-1:0] DENOM_5 = CHANGE_W'(5);
  localparam logic [CHANGE_W-1:0] DENOM_2 = CHANGE_W'(2);
  localparam logic [CHANGE_W-1:0] DENOM_1 = CHANGE_W'(1);

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StIssue,
    StWaitAck,
    StDone,
    StFault
  } cd_state_e;

  // One-hot denomination choice; all-zero means "none selected".
  typedef struct packed {
    logic d5;
    logic d2;
    logic d1;
  } denom_sel_t;

  function automatic logic [CHANGE_W-1:0] denom_value(input denom_sel_t sel);
    logic [CHANGE_W-1:0] val;
    val = '0;
    if (sel.d5) begin
      val = DENOM_5;
    end else if (sel.d2) begin
      val = DENOM_2;
    end else if (sel.d1) begin
      val = DENOM_1;
    end
    return val;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Handshake bundle between the vending controller / coin hopper side and the dispenser.
interface change_dispenser_if #(
  parameter int unsigned INV_W = 8
) ();
  import vm_pkg::*;

  logic [CHANGE_W-1:0] change_in;
  logic                change_valid;
  logic                hopper_done;
  logic                refill;
  logic                clr_fault;
  logic                coin_5;
  logic                coin_2;
  logic                coin_1;
  logic                busy;
  logic                done;
  logic                fault;
  logic [CHANGE_W-1:0] remaining;
  logic [INV_W-1:0]    inv5;
  logic [INV_W-1:0]    inv2;
  logic [INV_W-1:0]    inv1;

  // Requester / hopper side.
  modport master (
    output change_in, change_valid, hopper_done, refill, clr_fault,
    input  coin_5, coin_2, coin_1, busy, done, fault, remaining, inv5, inv2, inv1
  );

  // Dispenser side.
  modport slave (
    input  change_in, change_valid, hopper_done, refill, clr_fault,
    output coin_5, coin_2, coin_1, busy, done, fault, remaining, inv5, inv2, inv1
  );

endinterface

// File: rtl/coin_inventory.sv
// Per-denomination coin counters with refill and saturating decrement.
module coin_inventory #(
  parameter int unsigned INV_W    = 8,
  parameter int unsigned INV_INIT = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             refill,
  input  logic             dec5,
  input  logic             dec2,
  input  logic             dec1,
  output logic [INV_W-1:0] inv5,
  output logic [INV_W-1:0] inv2,
  output logic [INV_W-1:0] inv1,
  output logic             avail5,
  output logic             avail2,
  output logic             avail1
);

  localparam logic [INV_W-1:0] INIT = INV_W'(INV_INIT);
  localparam logic [INV_W-1:0] ONE  = INV_W'(1);

  logic [INV_W-1:0] inv5_q;
  logic [INV_W-1:0] inv2_q;
  logic [INV_W-1:0] inv1_q;

  // Refill wins; otherwise take one coin out, never wrapping below zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv5_q <= INIT;
      inv2_q <= INIT;
      inv1_q <= INIT;
    end else if (refill) begin
      inv5_q <= INIT;
      inv2_q <= INIT;
      inv1_q <= INIT;
    end else begin
      if (dec5 && (inv5_q != '0)) inv5_q <= inv5_q - ONE;
      if (dec2 && (inv2_q != '0)) inv2_q <= inv2_q - ONE;
      if (dec1 && (inv1_q != '0)) inv1_q <= inv1_q - ONE;
    end
  end

  // Availability flags consumed by the greedy selector.
  always_comb begin
    avail5 = (inv5_q != '0);
    avail2 = (inv2_q != '0);
    avail1 = (inv1_q != '0);
  end

  assign inv5 = inv5_q;
  assign inv2 = inv2_q;
  assign inv1 = inv1_q;

endmodule

// File: rtl/change_dispenser.sv
// Pays a change amount out as Rs 5/2/1 coins through a pulse/acknowledge coin hopper.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned INV_W          = 8,
  parameter int unsigned INV_INIT       = 20
) (
  input logic               clk,
  input logic               rst,
  change_dispenser_if.slave bus
);

  localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Last WAIT_ACK cycle: the timer would step to TIMEOUT_CYCLES-1 on this edge.
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 2);

  cd_state_e           state_q;
  logic [CHANGE_W-1:0] remaining_q;
  denom_sel_t          sel_q;
  denom_sel_t          coin_q;
  logic [TIMER_W-1:0]  timer_q;
  logic                busy_q;
  logic                done_q;
  logic                fault_q;

  denom_sel_t          sel_next;
  logic                sel_found;
  logic [CHANGE_W-1:0] sel_amt;
  logic                ack;
  logic                refill_en;

  logic [INV_W-1:0]    inv5;
  logic [INV_W-1:0]    inv2;
  logic [INV_W-1:0]    inv1;
  logic                avail5;
  logic                avail2;
  logic                avail1;

  coin_inventory #(
    .INV_W    (INV_W),
    .INV_INIT (INV_INIT)
  ) u_inventory (
    .clk    (clk),
    .rst    (rst),
    .refill (refill_en),
    .dec5   (ack && sel_q.d5),
    .dec2   (ack && sel_q.d2),
    .dec1   (ack && sel_q.d1),
    .inv5   (inv5),
    .inv2   (inv2),
    .inv1   (inv1),
    .avail5 (avail5),
    .avail2 (avail2),
    .avail1 (avail1)
  );

  // Greedy pick: largest coin that fits the unpaid amount and is still in stock.
  always_comb begin
    sel_next  = '0;
    sel_found = 1'b1;
    if ((remaining_q >= DENOM_5) && avail5) begin
      sel_next.d5 = 1'b1;
    end else if ((remaining_q >= DENOM_2) && avail2) begin
      sel_next.d2 = 1'b1;
    end else if ((remaining_q >= DENOM_1) && avail1) begin
      sel_next.d1 = 1'b1;
    end else begin
      sel_found = 1'b0;
    end
  end

  // Acknowledge and refill qualification.
  always_comb begin
    sel_amt   = denom_value(sel_q);
    ack       = (state_q == StWaitAck) && bus.hopper_done;
    refill_en = bus.refill && ((state_q == StIdle) || (state_q == StFault));
  end

  // Payout FSM; outputs are registered alongside the state they belong to.
  // done is registered off the DONE state, so it is visible the cycle after DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      sel_q       <= '0;
      coin_q      <= '0;
      timer_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      coin_q <= '0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.change_valid) begin
            busy_q <= 1'b1;
            if (bus.change_in != '0) begin
              remaining_q <= bus.change_in;
              state_q     <= StSelect;
            end else begin
              state_q <= StDone;
            end
          end
        end
        StSelect: begin
          if (sel_found) begin
            sel_q   <= sel_next;
            coin_q  <= sel_next;
            state_q <= StIssue;
          end else begin
            busy_q  <= 1'b0;
            fault_q <= 1'b1;
            state_q <= StFault;
          end
        end
        StIssue: begin
          timer_q <= '0;
          state_q <= StWaitAck;
        end
        StWaitAck: begin
          // An acknowledge on the timeout cycle still counts the coin.
          if (bus.hopper_done) begin
            remaining_q <= remaining_q - sel_amt;
            state_q     <= (remaining_q == sel_amt) ? StDone : StSelect;
          end else if (timer_q == TIMER_LAST) begin
            busy_q  <= 1'b0;
            fault_q <= 1'b1;
            state_q <= StFault;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end
        StDone: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        StFault: begin
          if (bus.clr_fault) begin
            remaining_q <= '0;
            fault_q     <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.coin_5    = coin_q.d5;
  assign bus.coin_2    = coin_q.d2;
  assign bus.coin_1    = coin_q.d1;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fault     = fault_q;
  assign bus.remaining = remaining_q;
  assign bus.inv5      = inv5;
  assign bus.inv2      = inv2;
  assign bus.inv1      = inv1;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with an automatic hopper responder.
module tb_change_dispenser;

  logic clk;
  logic rst;

  change_dispenser_if #(.INV_W(8)) bus ();

  change_dispenser #(
    .TIMEOUT_CYCLES (64),
    .INV_W          (8),
    .INV_INIT       (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Hopper responder settings and event log.
  bit hop_en  = 1'b0;
  int hop_lat = 3;
  int seq, n_coin, n_done, coin_cyc, done_cyc, fault_cyc;
  int strobe_cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log coin pulses (as a decimal digit sequence), done pulses and first fault.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.coin_5) begin seq = seq * 10 + 5; n_coin++; if (coin_cyc < 0) coin_cyc = cyc; end
      if (bus.coin_2) begin seq = seq * 10 + 2; n_coin++; if (coin_cyc < 0) coin_cyc = cyc; end
      if (bus.coin_1) begin seq = seq * 10 + 1; n_coin++; if (coin_cyc < 0) coin_cyc = cyc; end
      if (bus.done) begin n_done++; if (done_cyc < 0) done_cyc = cyc; end
      if (bus.fault && fault_cyc < 0) fault_cyc = cyc;
    end
  end

  // Hopper: acknowledge each coin hop_lat cycles after its pulse.
  always begin
    @(negedge clk);
    if (!rst && hop_en && (bus.coin_5 || bus.coin_2 || bus.coin_1)) begin
      repeat (hop_lat) @(posedge clk);
      #1;
      if (hop_en) bus.hopper_done = 1'b1;
      @(posedge clk);
      #1;
      bus.hopper_done = 1'b0;
    end
  end

  task automatic clr_log();
    seq = 0; n_coin = 0; n_done = 0; coin_cyc = -1; done_cyc = -1; fault_cyc = -1;
  endtask

  task automatic strobe(input logic [3:0] amt);
    @(posedge clk);
    #1;
    strobe_cyc       = cyc;
    bus.change_in    = amt;
    bus.change_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.change_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1; bus.clr_fault = 1'b1;
    @(posedge clk); #1; bus.clr_fault = 1'b0;
  endtask

  task automatic pulse_refill();
    @(posedge clk); #1; bus.refill = 1'b1;
    @(posedge clk); #1; bus.refill = 1'b0;
  endtask

  // Wait until done or fault shows up; timed_out reports an expired budget.
  task automatic wait_end(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done || bus.fault) begin
        timed_out = 1'b0;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input logic [3:0] amt, input int times, inout int n_to);
    bit to;
    for (int i = 0; i < times; i++) begin
      strobe(amt);
      wait_end(200, to);
      if (to) n_to++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.coin_5 !== 1'b0) begin n_fail++; $display("FAIL reset_coin_5: got %0b, expected 0", bus.coin_5); end
    n_checks++; if (bus.coin_2 !== 1'b0) begin n_fail++; $display("FAIL reset_coin_2: got %0b, expected 0", bus.coin_2); end
    n_checks++; if (bus.coin_1 !== 1'b0) begin n_fail++; $display("FAIL reset_coin_1: got %0b, expected 0", bus.coin_1); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b, expected 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b, expected 0", bus.done); end
    n_checks++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %0b, expected 0", bus.fault); end
    n_checks++; if (bus.remaining !== 4'd0) begin n_fail++; $display("FAIL reset_remaining: got %0d, expected 0", bus.remaining); end
    n_checks++; if (bus.inv5 !== 8'd20) begin n_fail++; $display("FAIL reset_inv5: got %0d, expected 20", bus.inv5); end
    n_checks++; if (bus.inv2 !== 8'd20) begin n_fail++; $display("FAIL reset_inv2: got %0d, expected 20", bus.inv2); end
    n_checks++; if (bus.inv1 !== 8'd20) begin n_fail++; $display("FAIL reset_inv1: got %0d, expected 20", bus.inv1); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_payout();
    bit to;
    clr_log();
    hop_en = 1'b1; hop_lat = 3;
    strobe(4'd8);
    wait_end(200, to);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL full_timeout: got %0b, expected 0", to); end
    n_checks++; if (seq != 521) begin n_fail++; $display("FAIL full_sequence: got %0d, expected 521", seq); end
    n_checks++; if (coin_cyc != strobe_cyc + 2) begin n_fail++; $display("FAIL full_first_coin_latency: got %0d, expected %0d", coin_cyc - strobe_cyc, 2); end
    n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL full_done_count: got %0d, expected 1", n_done); end
    n_checks++; if (bus.remaining !== 4'd0) begin n_fail++; $display("FAIL full_remaining: got %0d, expected 0", bus.remaining); end
    n_checks++; if (bus.inv5 !== 8'd19) begin n_fail++; $display("FAIL full_inv5: got %0d, expected 19", bus.inv5); end
    n_checks++; if (bus.inv2 !== 8'd19) begin n_fail++; $display("FAIL full_inv2: got %0d, expected 19", bus.inv2); end
    n_checks++; if (bus.inv1 !== 8'd19) begin n_fail++; $display("FAIL full_inv1: got %0d, expected 19", bus.inv1); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_after: got %0b, expected 0", bus.busy); end
  endtask

  task automatic test_no_fives();
    bit to;
    int n_to = 0;
    hop_en = 1'b1; hop_lat = 1;
    drain(4'd5, 19, n_to);
    n_checks++; if (n_to != 0) begin n_fail++; $display("FAIL nofive_drain_timeouts: got %0d, expected 0", n_to); end
    n_checks++; if (bus.inv5 !== 8'd0) begin n_fail++; $display("FAIL nofive_inv5_drained: got %0d, expected 0", bus.inv5); end
    clr_log();
    strobe(4'd4);
    wait_end(200, to);
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (seq != 22) begin n_fail++; $display("FAIL nofive_sequence: got %0d, expected 22", seq); end
    n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL nofive_done_count: got %0d, expected 1", n_done); end
    n_checks++; if (bus.inv2 !== 8'd17) begin n_fail++; $display("FAIL nofive_inv2: got %0d, expected 17", bus.inv2); end
    n_checks++; if (bus.inv1 !== 8'd19) begin n_fail++; $display("FAIL nofive_inv1: got %0d, expected 19", bus.inv1); end
    n_checks++; if (bus.inv5 !== 8'd0) begin n_fail++; $display("FAIL nofive_inv5_saturated: got %0d, expected 0", bus.inv5); end
  endtask

  task automatic test_unpayable();
    bit to;
    int n_to = 0;
    hop_en = 1'b1; hop_lat = 1;
    drain(4'd1, 19, n_to);
    drain(4'd2, 17, n_to);
    n_checks++; if (n_to != 0) begin n_fail++; $display("FAIL unpay_drain_timeouts: got %0d, expected 0", n_to); end
    n_checks++; if ({bus.inv2, bus.inv1} !== 16'd0) begin n_fail++; $display("FAIL unpay_drained: got inv2=%0d inv1=%0d, expected 0 0", bus.inv2, bus.inv1); end
    clr_log();
    strobe(4'd1);
    wait_end(50, to);
    n_checks++; if (bus.fault !== 1'b1) begin n_fail++; $display("FAIL unpay_fault: got %0b, expected 1", bus.fault); end
    n_checks++; if (n_coin != 0) begin n_fail++; $display("FAIL unpay_coin_count: got %0d, expected 0", n_coin); end
    n_checks++; if (bus.remaining !== 4'd1) begin n_fail++; $display("FAIL unpay_remaining: got %0d, expected 1", bus.remaining); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL unpay_busy: got %0b, expected 0", bus.busy); end
    // A new request while faulted must not be accepted.
    strobe(4'd7);
    @(posedge clk);
    #1;
    n_checks++; if (bus.remaining !== 4'd1) begin n_fail++; $display("FAIL unpay_strobe_in_fault: got %0d, expected 1", bus.remaining); end
    pulse_clr();
    n_checks++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL unpay_clr_fault: got %0b, expected 0", bus.fault); end
    n_checks++; if (bus.remaining !== 4'd0) begin n_fail++; $display("FAIL unpay_clr_remaining: got %0d, expected 0", bus.remaining); end
    pulse_refill();
    n_checks++; if ({bus.inv5, bus.inv2, bus.inv1} !== {8'd20, 8'd20, 8'd20}) begin
      n_fail++; $display("FAIL unpay_refill: got %0d %0d %0d, expected 20 20 20", bus.inv5, bus.inv2, bus.inv1);
    end
  endtask

  task automatic test_timeout();
    bit to;
    hop_en = 1'b0;
    clr_log();
    strobe(4'd5);
    wait_end(200, to);
    n_checks++; if (bus.fault !== 1'b1) begin n_fail++; $display("FAIL timeout_fault: got %0b, expected 1", bus.fault); end
    n_checks++; if (fault_cyc - coin_cyc != 64) begin n_fail++; $display("FAIL timeout_latency: got %0d, expected 64", fault_cyc - coin_cyc); end
    n_checks++; if (seq != 5) begin n_fail++; $display("FAIL timeout_sequence: got %0d, expected 5", seq); end
    n_checks++; if (bus.inv5 !== 8'd20) begin n_fail++; $display("FAIL timeout_inv5: got %0d, expected 20", bus.inv5); end
    n_checks++; if (bus.remaining !== 4'd5) begin n_fail++; $display("FAIL timeout_remaining: got %0d, expected 5", bus.remaining); end
    pulse_clr();
  endtask

  task automatic test_ack_on_timeout();
    bit to;
    hop_en = 1'b1; hop_lat = 63;
    clr_log();
    strobe(4'd5);
    wait_end(200, to);
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (fault_cyc != -1) begin n_fail++; $display("FAIL edge_ack_fault: got fault at cycle %0d, expected none", fault_cyc); end
    n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL edge_ack_done: got %0d, expected 1", n_done); end
    n_checks++; if (bus.inv5 !== 8'd19) begin n_fail++; $display("FAIL edge_ack_inv5: got %0d, expected 19", bus.inv5); end
    n_checks++; if (bus.remaining !== 4'd0) begin n_fail++; $display("FAIL edge_ack_remaining: got %0d, expected 0", bus.remaining); end
  endtask

  task automatic test_back_to_back();
    bit to;
    hop_en = 1'b1; hop_lat = 3;
    clr_log();
    strobe(4'd3);
    strobe(4'd9);
    wait_end(200, to);
    repeat (10) @(posedge clk);
    #1;
    n_checks++; if (seq != 21) begin n_fail++; $display("FAIL b2b_sequence: got %0d, expected 21", seq); end
    n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d, expected 1", n_done); end
    n_checks++; if (bus.inv2 !== 8'd19) begin n_fail++; $display("FAIL b2b_inv2: got %0d, expected 19", bus.inv2); end
    n_checks++; if (bus.inv1 !== 8'd19) begin n_fail++; $display("FAIL b2b_inv1: got %0d, expected 19", bus.inv1); end
    n_checks++; if (bus.remaining !== 4'd0) begin n_fail++; $display("FAIL b2b_remaining: got %0d, expected 0", bus.remaining); end
  endtask

  task automatic test_reset_mid_payout();
    bit to;
    hop_en = 1'b0;
    clr_log();
    strobe(4'd7);
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (n_coin != 1) begin n_fail++; $display("FAIL rstmid_coin_before: got %0d, expected 1", n_coin); end
    rst = 1'b1;
    #1;
    n_checks++; if ({bus.coin_5, bus.coin_2, bus.coin_1} !== 3'b000) begin n_fail++; $display("FAIL rstmid_coins: got %b, expected 000", {bus.coin_5, bus.coin_2, bus.coin_1}); end
    n_checks++; if ({bus.busy, bus.done, bus.fault} !== 3'b000) begin n_fail++; $display("FAIL rstmid_flags: got %b, expected 000", {bus.busy, bus.done, bus.fault}); end
    n_checks++; if (bus.remaining !== 4'd0) begin n_fail++; $display("FAIL rstmid_remaining: got %0d, expected 0", bus.remaining); end
    n_checks++; if ({bus.inv5, bus.inv2, bus.inv1} !== {8'd20, 8'd20, 8'd20}) begin
      n_fail++; $display("FAIL rstmid_inventory: got %0d %0d %0d, expected 20 20 20", bus.inv5, bus.inv2, bus.inv1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr_log();
    repeat (80) @(posedge clk);
    #1;
    n_checks++; if (n_coin != 0 || fault_cyc != -1) begin n_fail++; $display("FAIL rstmid_quiet: got coins=%0d fault_cyc=%0d, expected 0 -1", n_coin, fault_cyc); end
    strobe(4'd0);
    wait_end(20, to);
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (done_cyc != strobe_cyc + 2) begin n_fail++; $display("FAIL zero_done_latency: got %0d, expected 2", done_cyc - strobe_cyc); end
    n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL zero_done_count: got %0d, expected 1", n_done); end
    n_checks++; if (n_coin != 0) begin n_fail++; $display("FAIL zero_coin_count: got %0d, expected 0", n_coin); end
  endtask

  initial begin
    rst              = 1'b1;
    bus.change_in    = '0;
    bus.change_valid = 1'b0;
    bus.hopper_done  = 1'b0;
    bus.refill       = 1'b0;
    bus.clr_fault    = 1'b0;
    clr_log();
    test_reset();
    test_full_payout();
    test_no_fives();
    test_unpayable();
    test_timeout();
    test_ack_on_timeout();
    test_back_to_back();
    test_reset_mid_payout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
